wb_trace_monitor: RTL and testbench
===================================

Name: wb_trace_monitor

Overview:
Synthesizable, parametrised successor to the simulation-only register monitor. It snoops the processor write-back port. Every qualifying register write is logged into a circular trace FIFO, and a shadow copy of the register file is kept. On request, the shadow copy is streamed out one register at a time over a valid/ready port. The block sits beside risc_v_processor and taps the rd/write_back_data/reg_write signals, so on-chip or bench logic can read the write-back trace and the final register state without hierarchical peeking.

Parameters:
XLEN, 32, data width of register values
NUM_REGS, 32, number of architectural registers; index width RW = clog2(NUM_REGS)
DEPTH, 16, trace FIFO entries (power of two, >=2)
WRAP_MODE, 0, 0 = drop new entries when full; 1 = overwrite oldest entry when full
FILTER_X0, 1, 1 = writes to register 0 are neither traced nor shadowed

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
wb_en  in  1  write-back strobe (reg_write)
wb_rd  in  RW  destination register index
wb_data  in  XLEN  write-back value
tr_valid  out  1  trace head entry available
tr_ready  in  1  consumer accepts head entry
tr_rd  out  RW  head entry register index
tr_data  out  XLEN  head entry value
tr_seq  out  16  head entry sequence number
tr_count  out  clog2(DEPTH)+1  entries held
tr_overflow  out  1  sticky: at least one entry was dropped or overwritten
dump_req  in  1  start a shadow-register dump
dump_valid  out  1  dump word valid
dump_ready  in  1  dump word accepted
dump_idx  out  RW  register index of dump word
dump_data  out  XLEN  shadow value of dump_idx
dump_busy  out  1  dump in progress
dump_done  out  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset: FIFO empty, all pointers and the sequence counter = 0, every shadow register = 0, tr_overflow = 0, FSM = IDLE, and every output = 0.
- Qualifying write: wb_en=1, and additionally wb_rd!=0 when FILTER_X0=1.
  - Each qualifying write increments the 16-bit sequence counter, which wraps 0xFFFF->0x0000.
  - Dropped writes still consume a sequence number, so gaps reveal losses.
- Shadow update: a qualifying write sets shadow[wb_rd] <= wb_data at the clock edge. The value is visible on dump_data from the next cycle.
- Push: a qualifying write stores {wb_rd, wb_data, seq}.
  - Latency: the entry is visible on the tr_* outputs the cycle after wb_en if the FIFO was empty.
- tr_valid = (tr_count != 0). The tr_* outputs present the head entry and hold stable while tr_valid=1 and tr_ready=0.
- Pop: tr_valid && tr_ready. A pop when empty is a no-op.
- Pointers wrap modulo DEPTH.
- Full, push, no pop:
  - WRAP_MODE=0: the new entry is discarded and tr_overflow is set.
  - WRAP_MODE=1: the oldest entry is overwritten, the head pointer advances, tr_count stays at DEPTH, and tr_overflow is set.
- Full, push and pop in the same cycle: both succeed, tr_count is unchanged, and there is no overflow.
- Empty, push and pop in the same cycle: only the push takes effect, since tr_valid was 0.
- tr_overflow clears only on rst.
- Dump FSM states: IDLE, SCAN, DONE.
  - IDLE: dump_req=1 -> SCAN with dump_idx=0. dump_req in any other state is ignored.
  - SCAN: dump_valid=1 and dump_busy=1. On each handshake dump_idx increments. A handshake at dump_idx=NUM_REGS-1 -> DONE.
  - DONE: dump_done=1 for exactly one cycle, dump_valid=0, busy=0 -> IDLE.
- dump_data reads shadow[dump_idx] combinationally.
  - A write to the same index in the same cycle as a handshake: the old value is transferred.
  - While dump_valid=1 and dump_ready=0, dump_data may change only if a write-back targets dump_idx.
- Tracing continues during a dump.
- rst asserted mid-dump or mid-trace: everything returns to the reset state on that edge.

Test Plan:
- Reset, then writes x5=0x11, x6=0x22, x0=0x99 (FILTER_X0=1), tr_ready=0 -> tr_count=2, head {5,0x11,seq 0}. Pop twice -> {6,0x22,seq 1}, then tr_valid=0.
- WRAP_MODE=0, DEPTH=4, 6 writes x1..x6 with no pops -> tr_count=4, tr_overflow=1, drained order x1..x4 with seq 0..3.
- WRAP_MODE=1, same stimulus -> drained order x3..x6 with seq 2..5, tr_overflow=1.
- Full FIFO, push and pop in the same cycle -> tr_count stays 4, tr_overflow stays 0, new entry at the tail.
- Writes x3=7, x31=0xDEADBEEF; dump_req with dump_ready toggling 1,0,1,... -> 32 words idx 0..31 with data[3]=7, data[31]=0xDEADBEEF, others 0; dump_done pulses once; a second dump_req during SCAN is ignored.
- rst pulsed at dump_idx=10 with 3 entries queued -> next cycle dump_busy=0, tr_count=0, shadow reads 0 on a new dump.

Source files
------------

// File: rtl/wb_trace_if.sv
// wb_trace_if: write-back snoop, trace stream and register-dump signals of wb_trace_monitor.
interface wb_trace_if #(
  parameter int XLEN = 32,
  parameter int NUM_REGS = 32,
  parameter int DEPTH = 16
);
  localparam int RW = $clog2(NUM_REGS);
  localparam int CW = $clog2(DEPTH) + 1;
  logic            wb_en;
  logic [RW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            tr_valid;
  logic            tr_ready;
  logic [RW-1:0]   tr_rd;
  logic [XLEN-1:0] tr_data;
  logic [15:0]     tr_seq;
  logic [CW-1:0]   tr_count;
  logic            tr_overflow;
  logic            dump_req;
  logic            dump_valid;
  logic            dump_ready;
  logic [RW-1:0]   dump_idx;
  logic [XLEN-1:0] dump_data;
  logic            dump_busy;
  logic            dump_done;
  modport master (
    output wb_en, wb_rd, wb_data, tr_ready, dump_req, dump_ready,
    input  tr_valid, tr_rd, tr_data, tr_seq, tr_count, tr_overflow,
           dump_valid, dump_idx, dump_data, dump_busy, dump_done
  );
  modport slave (
    input  wb_en, wb_rd, wb_data, tr_ready, dump_req, dump_ready,
    output tr_valid, tr_rd, tr_data, tr_seq, tr_count, tr_overflow,
           dump_valid, dump_idx, dump_data, dump_busy, dump_done
  );
endinterface

// File: rtl/wb_trace_monitor.sv
// wb_trace_monitor: write-back trace FIFO plus shadow register file streamed out on request.
module wb_trace_monitor #(
  parameter int XLEN = 32,
  parameter int NUM_REGS = 32,
  parameter int DEPTH = 16,
  parameter int WRAP_MODE = 0,
  parameter int FILTER_X0 = 1
) (
  input logic clk,
  input logic rst,
  wb_trace_if.slave bus
);
  localparam int RW = $clog2(NUM_REGS);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = RW + XLEN + 16;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  logic [EW-1:0]   fifo_q [DEPTH];
  logic [XLEN-1:0] shadow_q [NUM_REGS];
  logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     seq_q, seq_d;
  logic            ovf_q, ovf_d, qual, full, pop, push, adv;
  state_t          state_q, state_d;
  logic [RW-1:0]   idx_q, idx_d;
  always_comb begin
    qual = bus.wb_en && (FILTER_X0 == 0 || bus.wb_rd != '0);
    full = count_q == CW'(DEPTH);
    pop = count_q != '0 && bus.tr_ready;
    push = qual && (!full || pop || WRAP_MODE != 0);
    // in wrap mode a full FIFO drops its oldest entry to make room
    adv = pop || (qual && full && WRAP_MODE != 0);
    head_d = head_q + AW'(adv);
    tail_d = tail_q + AW'(push);
    count_d = count_q + CW'(push) - CW'(adv);
    seq_d = seq_q + 16'(qual);
    ovf_d = ovf_q || (qual && full && !pop);
    state_d = state_q == IDLE ? (bus.dump_req ? SCAN : IDLE) :
              state_q == DONE ? IDLE :
              (bus.dump_ready && idx_q == RW'(NUM_REGS - 1)) ? DONE : SCAN;
    idx_d = (state_q == SCAN && state_d == SCAN) ? idx_q + RW'(bus.dump_ready) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      seq_q <= '0;
      ovf_q <= 1'b0;
      state_q <= IDLE;
      idx_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      seq_q <= seq_d;
      ovf_q <= ovf_d;
      state_q <= state_d;
      idx_q <= idx_d;
      if (push) fifo_q[tail_q] <= {bus.wb_rd, bus.wb_data, seq_q};
      if (qual) shadow_q[bus.wb_rd] <= bus.wb_data;
    end
  end
  assign bus.tr_valid = count_q != '0;
  assign {bus.tr_rd, bus.tr_data, bus.tr_seq} = bus.tr_valid ? fifo_q[head_q] : '0;
  assign bus.tr_count = count_q;
  assign bus.tr_overflow = ovf_q;
  assign bus.dump_valid = state_q == SCAN;
  assign bus.dump_busy = state_q == SCAN;
  assign bus.dump_done = state_q == DONE;
  assign bus.dump_idx = idx_q;
  assign bus.dump_data = shadow_q[idx_q];
endmodule

// File: tb/tb_wb_trace_monitor.sv
// tb_wb_trace_monitor: drop-mode and wrap-mode monitors driven in lockstep against queue scoreboards.
module tb_wb_trace_monitor;
  typedef struct {logic [4:0] rd; logic [31:0] data; logic [15:0] seq;} ent_t;
  logic clk = 0, rst = 0, wb_en = 0, tr_ready = 0, dump_req = 0, dump_ready = 0;
  logic [4:0] wb_rd = 0;
  logic [31:0] wb_data = 0;
  int checks = 0, errors = 0;
  ent_t q0[$], q1[$];
  logic [15:0] m_seq;
  bit m_qual, m_p0, m_p1, m_f0, m_f1;
  wb_trace_if #(.XLEN(32), .NUM_REGS(32), .DEPTH(4)) i0 ();
  wb_trace_if #(.XLEN(32), .NUM_REGS(32), .DEPTH(4)) i1 ();
  assign i0.wb_en = wb_en;       assign i1.wb_en = wb_en;
  assign i0.wb_rd = wb_rd;       assign i1.wb_rd = wb_rd;
  assign i0.wb_data = wb_data;   assign i1.wb_data = wb_data;
  assign i0.tr_ready = tr_ready; assign i1.tr_ready = tr_ready;
  assign i0.dump_req = dump_req; assign i1.dump_req = dump_req;
  assign i0.dump_ready = dump_ready; assign i1.dump_ready = dump_ready;
  wb_trace_monitor #(.DEPTH(4), .WRAP_MODE(0)) u0 (.clk(clk), .rst(rst), .bus(i0));
  wb_trace_monitor #(.DEPTH(4), .WRAP_MODE(1)) u1 (.clk(clk), .rst(rst), .bus(i1));
  always #5 clk = ~clk;
  // scoreboard: q0 models drop-on-full, q1 models overwrite-oldest
  always @(posedge clk) begin
    if (rst) begin
      q0.delete(); q1.delete(); m_seq = 0;
    end else begin
      m_qual = wb_en && wb_rd != 0;
      m_p0 = tr_ready && q0.size() != 0;
      m_p1 = tr_ready && q1.size() != 0;
      m_f0 = q0.size() == 4;
      m_f1 = q1.size() == 4;
      if (m_p0) void'(q0.pop_front());
      if (m_p1) void'(q1.pop_front());
      if (m_qual) begin
        if (!m_f0 || m_p0) q0.push_back('{wb_rd, wb_data, m_seq});
        if (m_f1 && !m_p1) void'(q1.pop_front());
        q1.push_back('{wb_rd, wb_data, m_seq});
        m_seq = m_seq + 1;
      end
    end
  end
  task automatic do_reset();
    rst = 1; wb_en = 0; tr_ready = 0; dump_req = 0; dump_ready = 0;
    @(negedge clk); @(negedge clk);
    rst = 0;
  endtask
  task automatic wb_write(input logic [4:0] rd, input logic [31:0] d);
    wb_en = 1; wb_rd = rd; wb_data = d;
    @(negedge clk);
    wb_en = 0;
  endtask
  task automatic test_reset();
    wb_write(5, 32'h1); wb_write(6, 32'h2);
    do_reset();
    checks++; if (i0.tr_valid !== 0 || i1.tr_valid !== 0) begin errors++; $display("FAIL reset_valid got %b/%b want 0", i0.tr_valid, i1.tr_valid); end
    checks++; if (i0.tr_count !== 0 || i0.tr_overflow !== 0) begin errors++; $display("FAIL reset_count got %0d ovf %b want 0", i0.tr_count, i0.tr_overflow); end
    checks++; if (i0.tr_rd !== 0 || i0.tr_data !== 0 || i0.tr_seq !== 0) begin errors++; $display("FAIL reset_head got %0d %h %0d want 0", i0.tr_rd, i0.tr_data, i0.tr_seq); end
    checks++; if (i0.dump_valid !== 0 || i0.dump_busy !== 0 || i0.dump_done !== 0 || i0.dump_idx !== 0 || i0.dump_data !== 0) begin errors++; $display("FAIL reset_dump got v%b b%b d%b idx %0d data %h want 0", i0.dump_valid, i0.dump_busy, i0.dump_done, i0.dump_idx, i0.dump_data); end
  endtask
  task automatic test_basic();
    do_reset();
    wb_write(5, 32'h11);
    checks++; if (i0.tr_valid !== 1 || i0.tr_data !== 32'h11) begin errors++; $display("FAIL basic_latency got v%b %h want 1 11", i0.tr_valid, i0.tr_data); end
    wb_write(6, 32'h22); wb_write(0, 32'h99);
    checks++; if (i0.tr_count !== 2 || i1.tr_count !== 2) begin errors++; $display("FAIL basic_count got %0d/%0d want 2", i0.tr_count, i1.tr_count); end
    checks++; if (i0.tr_rd !== 5 || i0.tr_data !== 32'h11 || i0.tr_seq !== 0) begin errors++; $display("FAIL basic_head got %0d %h %0d want 5 11 0", i0.tr_rd, i0.tr_data, i0.tr_seq); end
    tr_ready = 1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (q0.size() == 0) begin errors++; $display("FAIL basic_sb empty scoreboard at pop %0d", k); end
      else if (i0.tr_rd !== q0[0].rd || i0.tr_data !== q0[0].data || i0.tr_seq !== q0[0].seq || i0.tr_seq !== 16'(k)) begin
        errors++; $display("FAIL basic_pop%0d got %0d %h %0d want %0d %h %0d", k, i0.tr_rd, i0.tr_data, i0.tr_seq, q0[0].rd, q0[0].data, q0[0].seq);
      end
      @(negedge clk);
    end
    tr_ready = 0;
    checks++; if (i0.tr_valid !== 0 || i1.tr_valid !== 0) begin errors++; $display("FAIL basic_empty got %b/%b want 0", i0.tr_valid, i1.tr_valid); end
  endtask
  task automatic test_overflow();
    do_reset();
    for (int k = 1; k <= 6; k++) wb_write(5'(k), 32'h100 + k);
    checks++; if (i0.tr_count !== 4 || i1.tr_count !== 4) begin errors++; $display("FAIL ovf_count got %0d/%0d want 4", i0.tr_count, i1.tr_count); end
    checks++; if (i0.tr_overflow !== 1 || i1.tr_overflow !== 1) begin errors++; $display("FAIL ovf_flag got %b/%b want 1", i0.tr_overflow, i1.tr_overflow); end
    tr_ready = 1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (q0.size() == 0 || i0.tr_rd !== 5'(k + 1) || i0.tr_seq !== 16'(k) || i0.tr_data !== 32'h101 + k || i0.tr_seq !== q0[0].seq) begin
        errors++; $display("FAIL ovf_drop%0d got %0d %h %0d want %0d %h %0d", k, i0.tr_rd, i0.tr_data, i0.tr_seq, k + 1, 32'h101 + k, k);
      end
      checks++;
      if (q1.size() == 0 || i1.tr_rd !== 5'(k + 3) || i1.tr_seq !== 16'(k + 2) || i1.tr_data !== 32'h103 + k || i1.tr_seq !== q1[0].seq) begin
        errors++; $display("FAIL ovf_wrap%0d got %0d %h %0d want %0d %h %0d", k, i1.tr_rd, i1.tr_data, i1.tr_seq, k + 3, 32'h103 + k, k + 2);
      end
      @(negedge clk);
    end
    tr_ready = 0;
    checks++; if (i0.tr_valid !== 0 || i1.tr_valid !== 0 || i0.tr_overflow !== 1 || i1.tr_overflow !== 1) begin errors++; $display("FAIL ovf_after got v%b/%b o%b/%b want 0 0 1 1", i0.tr_valid, i1.tr_valid, i0.tr_overflow, i1.tr_overflow); end
  endtask
  task automatic test_full_push_pop();
    logic [4:0] exp_rd [4] = '{5'd2, 5'd3, 5'd4, 5'd7};
    do_reset();
    for (int k = 1; k <= 4; k++) wb_write(5'(k), 32'h200 + k);
    tr_ready = 1; wb_en = 1; wb_rd = 7; wb_data = 32'h207;
    checks++; if (i0.tr_rd !== 1 || i1.tr_rd !== 1) begin errors++; $display("FAIL fpp_head got %0d/%0d want 1", i0.tr_rd, i1.tr_rd); end
    @(negedge clk);
    wb_en = 0; tr_ready = 0;
    checks++; if (i0.tr_count !== 4 || i1.tr_count !== 4) begin errors++; $display("FAIL fpp_count got %0d/%0d want 4", i0.tr_count, i1.tr_count); end
    checks++; if (i0.tr_overflow !== 0 || i1.tr_overflow !== 0) begin errors++; $display("FAIL fpp_ovf got %b/%b want 0", i0.tr_overflow, i1.tr_overflow); end
    tr_ready = 1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (q0.size() == 0 || q1.size() == 0 || i0.tr_rd !== exp_rd[k] || i1.tr_rd !== exp_rd[k] || i0.tr_data !== q0[0].data || i1.tr_seq !== q1[0].seq) begin
        errors++; $display("FAIL fpp_drain%0d got %0d/%0d want %0d", k, i0.tr_rd, i1.tr_rd, exp_rd[k]);
      end
      @(negedge clk);
    end
    wb_en = 1; wb_rd = 9; wb_data = 32'h99;
    @(negedge clk);
    wb_en = 0; tr_ready = 0;
    checks++; if (i0.tr_count !== 1 || i0.tr_rd !== 9 || i0.tr_seq !== 5) begin errors++; $display("FAIL empty_push_pop got cnt %0d rd %0d seq %0d want 1 9 5", i0.tr_count, i0.tr_rd, i0.tr_seq); end
  endtask
  task automatic test_dump();
    int words = 0, dones = 0;
    logic [31:0] exp;
    do_reset();
    wb_write(3, 32'h7); wb_write(31, 32'hDEADBEEF); wb_write(0, 32'h99);
    dump_req = 1;
    @(negedge clk);
    dump_req = 0;
    for (int c = 0; c < 80; c++) begin
      dump_ready = (c % 2 == 0);
      dump_req = (c == 5);
      if (c == 0) begin
        checks++; if (i0.dump_busy !== 1 || i0.dump_valid !== 1) begin errors++; $display("FAIL dump_busy got b%b v%b want 1", i0.dump_busy, i0.dump_valid); end
      end
      if (i0.dump_done) dones++;
      wb_en = 0;
      if (i0.dump_valid && dump_ready) begin
        exp = words == 3 ? 32'h7 : words == 31 ? 32'hDEADBEEF : 32'h0;
        checks++;
        if (i0.dump_idx !== 5'(words) || i0.dump_data !== exp || i1.dump_data !== exp) begin
          errors++; $display("FAIL dump_word%0d got idx %0d data %h want idx %0d data %h", words, i0.dump_idx, i0.dump_data, words, exp);
        end
        // same-edge write to the index being handed over must not alter the word sent
        if (words == 3) begin wb_en = 1; wb_rd = 3; wb_data = 32'h77; end
        words++;
      end
      @(negedge clk);
    end
    wb_en = 0; dump_ready = 0; dump_req = 0;
    checks++; if (words != 32) begin errors++; $display("FAIL dump_words got %0d want 32", words); end
    checks++; if (dones != 1) begin errors++; $display("FAIL dump_done_pulses got %0d want 1", dones); end
    checks++; if (i0.dump_busy !== 0 || i0.dump_valid !== 0) begin errors++; $display("FAIL dump_idle got b%b v%b want 0", i0.dump_busy, i0.dump_valid); end
    checks++; if (i0.tr_count !== 3 || i1.tr_count !== 3) begin errors++; $display("FAIL dump_trace got %0d/%0d want 3", i0.tr_count, i1.tr_count); end
  endtask
  task automatic test_rst_mid_dump();
    int words = 0;
    bit found = 0;
    do_reset();
    wb_write(3, 32'h7); wb_write(4, 32'h8); wb_write(5, 32'h9);
    checks++; if (i0.tr_count !== 3) begin errors++; $display("FAIL rst_pre_count got %0d want 3", i0.tr_count); end
    dump_req = 1;
    @(negedge clk);
    dump_req = 0; dump_ready = 1;
    for (int c = 0; c < 60 && !found; c++) begin
      if (i0.dump_idx == 10 && i0.dump_valid) found = 1;
      else @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL rst_wait timeout idx %0d want 10", i0.dump_idx); end
    rst = 1;
    @(negedge clk);
    rst = 0; dump_ready = 0;
    checks++; if (i0.dump_busy !== 0 || i0.dump_valid !== 0 || i0.dump_idx !== 0) begin errors++; $display("FAIL rst_dump got b%b v%b idx %0d want 0", i0.dump_busy, i0.dump_valid, i0.dump_idx); end
    checks++; if (i0.tr_count !== 0 || i1.tr_count !== 0 || i0.tr_valid !== 0) begin errors++; $display("FAIL rst_trace got %0d/%0d want 0", i0.tr_count, i1.tr_count); end
    dump_req = 1;
    @(negedge clk);
    dump_req = 0; dump_ready = 1;
    for (int c = 0; c < 40; c++) begin
      if (i0.dump_valid) begin
        checks++;
        if (i0.dump_idx !== 5'(words) || i0.dump_data !== 0) begin errors++; $display("FAIL rst_shadow%0d got idx %0d data %h want 0", words, i0.dump_idx, i0.dump_data); end
        words++;
      end
      @(negedge clk);
    end
    dump_ready = 0;
    checks++; if (words != 32) begin errors++; $display("FAIL rst_redump_words got %0d want 32", words); end
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_dump();
    test_rst_mid_dump();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
